// File: rtl/toggle_event_decoder.sv
// ---------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive end of a toggle-encoded event line. The sender flips its output
// once per event; every level change seen here is turned back into one
// discrete event. Events queue up in a saturating pending counter and are
// handed to a consumer over a valid/ready handshake. A wrapping total-event
// counter and a sticky overflow flag record every detected event, including
// the ones dropped while the queue was full.
//
// Optional build macro:
//   TOGGLE_EVENT_DECODER_SYNC_EN - route tog_in through a 2-flop
//   synchronizer for a sender in a foreign clock domain. This adds two
//   cycles of latency. The startup phase also waits until the synchronizer
//   holds a real sample before it captures the reference level.
//
// Parameters:
//   CNT_W        width of the pending counter (max pending = 2^CNT_W-1)
//   TOT_W        width of the total-event counter (wraps)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   tog_in       toggle-encoded event line
//   enable       1 = detect events, 0 = absorb level changes silently
//   ev_ready     consumer takes one event this cycle when ev_valid=1
//   overflow_clr synchronous clear of the overflow flag
//   ev_valid     at least one event pending
//   pending      number of queued events
//   overflow     sticky: an event arrived while pending was saturated
//   total_count  all detected events, wrapping
// ---------------------------------------------------------------------------
module toggle_event_decoder #(
  parameter int CNT_W = 4,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             enable,
  input  logic             ev_ready,
  input  logic             overflow_clr,
  output logic             ev_valid,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic [TOT_W-1:0] total_count
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t state;
  state_t state_nxt;
  logic   s;
  logic   ref_lvl;
  logic   detect;
  logic   accept;

`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
  logic       sync1;
  logic       sync2;
  logic [1:0] init_cnt;
  logic [1:0] init_cnt_nxt;

  // Two-flop synchronizer for a sender in another clock domain. Both flops
  // clear on reset, so the startup phase must wait until real samples have
  // moved through them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tog_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = tog_in;
`endif

  // State register. With the synchronizer, a small counter also measures
  // the startup edges so that the reference level is captured only after
  // the synchronizer output shows the true line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
      init_cnt <= 2'd0;
`endif
    end else begin
      state    <= state_nxt;
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
      init_cnt <= init_cnt_nxt;
`endif
    end
  end

  // Next-state logic. S_INIT lasts one edge without the synchronizer and
  // three edges with it. S_RUN is left only through reset.
  always_comb begin
    state_nxt    = state;
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
    init_cnt_nxt = init_cnt;
`endif
    case (state)
      S_INIT: begin
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
        if (init_cnt == 2'd2) begin
          state_nxt = S_RUN;
        end else begin
          init_cnt_nxt = init_cnt + 2'd1;
        end
`else
        state_nxt = S_RUN;
`endif
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Output logic. An event is a difference between the current sample and
  // the reference level, and it counts only in S_RUN. The startup level is
  // therefore never reported as an event.
  always_comb begin
    detect = 1'b0;
    if (state == S_RUN) begin
      detect = (s != ref_lvl) && enable;
    end
  end

  // The reference level follows the sample on every edge, in both states
  // and whether or not detection is enabled. In S_INIT this is the startup
  // capture. When enable=0, level changes are absorbed here, so turning
  // detection back on never produces a stale event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_lvl <= 1'b0;
    end else begin
      ref_lvl <= s;
    end
  end

  assign ev_valid = (pending != '0);
  assign accept   = ev_valid && ev_ready;

  // Pending queue depth. A new event and a consumed event in the same cycle
  // cancel out. A new event with the queue full is dropped here and
  // recorded by the overflow flag instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (detect && !accept) begin
      if (pending != PEND_MAX) begin
        pending <= pending + 1'b1;
      end
    end else if (!detect && accept) begin
      pending <= pending - 1'b1;
    end
  end

  // Sticky overflow flag. The set condition is checked first so that an
  // overflow arriving in the same cycle as a clear is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (detect && !accept && (pending == PEND_MAX)) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Running count of every detected event, including dropped ones. The
  // count wraps naturally at the counter width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_count <= '0;
    end else if (detect) begin
      total_count <= total_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_event_decoder
//
// Self-checking bench for toggle_event_decoder. A behavioural model keeps a
// short history of line samples and derives events, queue depth, overflow
// and the running total as plain integers. One compare process checks the
// DUT against the model on every falling edge. Directed scenarios add
// hand-computed literal expectations, and a randomized phase follows them.
// Build with TOGGLE_EVENT_DECODER_SYNC_EN defined to cover the
// synchronizer variant.
// ---------------------------------------------------------------------------
module tb_toggle_event_decoder;

  localparam int CNT_W = 4;
  localparam int TOT_W = 16;
  localparam int PMAX  = (1 << CNT_W) - 1;
`ifdef TOGGLE_EVENT_DECODER_SYNC_EN
  localparam int LAT   = 2;
  localparam int PRIME = 3;
`else
  localparam int LAT   = 0;
  localparam int PRIME = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tog = 1'b1;
  logic             en = 1'b1;
  logic             rdy = 1'b0;
  logic             clr = 1'b0;
  logic             ev_valid;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic [TOT_W-1:0] total_count;

  int totalChecks = 0;
  int badChecks = 0;

  int mEdges = 0;
  int mPending = 0;
  int mTotal = 0;
  bit mOverflow = 1'b0;
  bit mPrevS = 1'b0;
  bit togHist[$];

  toggle_event_decoder #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .tog_in       (tog),
    .enable       (en),
    .ev_ready     (rdy),
    .overflow_clr (clr),
    .ev_valid     (ev_valid),
    .pending      (pending),
    .overflow     (overflow),
    .total_count  (total_count)
  );

  always #5 clk = ~clk;

  // Watchdog so that the run always ends, even if the sequence stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a falling edge and stay stable across the
  // following rising edge.
  task automatic applyStimulus(input logic t, input logic e, input logic r, input logic c);
    @(negedge clk);
    tog = t;
    en  = e;
    rdy = r;
    clr = c;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model. The sample seen at edge k is the line level from
  // LAT edges earlier, or 0 while the synchronizer is still filling. Edges
  // up to PRIME only establish the reference level. After that, any
  // sample-to-sample difference with enable high is one event.
  always @(posedge clk or posedge reset) begin
    bit curS;
    bit ev;
    bit acc;
    bit setNow;
    if (reset) begin
      mEdges    = 0;
      togHist.delete();
      mPrevS    = 1'b0;
      mPending  = 0;
      mOverflow = 1'b0;
      mTotal    = 0;
    end else begin
      mEdges++;
      togHist.push_back(tog);
      if (togHist.size() > LAT + 2) void'(togHist.pop_front());
      curS   = (togHist.size() > LAT) ? togHist[togHist.size() - 1 - LAT] : 1'b0;
      ev     = (mEdges > PRIME) && en && (curS != mPrevS);
      mPrevS = curS;
      acc    = (mPending > 0) && rdy;
      setNow = ev && !acc && (mPending == PMAX);
      if (ev && !acc) begin
        if (mPending < PMAX) mPending++;
      end else if (!ev && acc) begin
        mPending--;
      end
      if (ev) mTotal = (mTotal + 1) % (1 << TOT_W);
      if (setNow) mOverflow = 1'b1;
      else if (clr) mOverflow = 1'b0;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("pending", int'(pending), mPending);
    checkOutput("ev_valid", int'(ev_valid), int'(mPending != 0));
    checkOutput("overflow", int'(overflow), int'(mOverflow));
    checkOutput("total_count", int'(total_count), mTotal);
  end

  initial begin
    int n;
    $display("[TB] start, synchronizer latency = %0d", LAT);

    // Reset release with the line already high: no event is generated.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_startup_pending", int'(pending), 0);
    checkOutput("lit_startup_total", int'(total_count), 0);

    // Three toggles two cycles apart with ready low, then drain.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (LAT) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_three_pending", int'(pending), 3);
    checkOutput("lit_three_valid", int'(ev_valid), 1);
    checkOutput("lit_three_total", int'(total_count), 3);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("lit_drain_pending", int'(pending), 0);
    checkOutput("lit_drain_valid", int'(ev_valid), 0);

    // Toggle every cycle while the consumer keeps up.
    for (int i = 0; i < 12; i++) applyStimulus(~tog, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("lit_stream_pending", int'(pending), 1);
    checkOutput("lit_stream_overflow", int'(overflow), 0);
    repeat (LAT + 2) applyStimulus(tog, 1'b1, 1'b1, 1'b0);

    // Saturation: 17 events with ready low, then clear and set-beats-clear.
    doReset();
    repeat (3) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(~tog, 1'b1, 1'b0, 1'b0);
    repeat (LAT) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_sat_pending", int'(pending), 15);
    checkOutput("lit_sat_overflow", int'(overflow), 1);
    checkOutput("lit_sat_total", int'(total_count), 17);
    applyStimulus(tog, 1'b1, 1'b0, 1'b1);
    settle();
    checkOutput("lit_clr_overflow", int'(overflow), 0);
    for (int j = 0; j <= LAT; j++) applyStimulus((j == 0) ? ~tog : tog, 1'b1, 1'b0, (j == LAT));
    settle();
    checkOutput("lit_setwins_overflow", int'(overflow), 1);
    checkOutput("lit_setwins_total", int'(total_count), 18);
    checkOutput("lit_setwins_pending", int'(pending), 15);
    repeat (17) applyStimulus(tog, 1'b1, 1'b1, 1'b0);
    applyStimulus(tog, 1'b1, 1'b0, 1'b1);

    // Changes while disabled are absorbed; re-enabling creates no event.
    applyStimulus(~tog, 1'b0, 1'b0, 1'b0);
    applyStimulus(tog, 1'b0, 1'b0, 1'b0);
    applyStimulus(~tog, 1'b0, 1'b0, 1'b0);
    repeat (LAT + 1) applyStimulus(tog, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_reenable_pending", int'(pending), 0);
    applyStimulus(~tog, 1'b1, 1'b0, 1'b0);
    repeat (LAT) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_after_enable_pending", int'(pending), 1);
    repeat (2) applyStimulus(tog, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset with five events queued.
    for (int i = 0; i < 5; i++) applyStimulus(~tog, 1'b1, 1'b0, 1'b0);
    repeat (LAT) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("lit_prereset_pending", int'(pending), 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("lit_async_pending", int'(pending), 0);
    checkOutput("lit_async_valid", int'(ev_valid), 0);
    checkOutput("lit_async_overflow", int'(overflow), 0);
    checkOutput("lit_async_total", int'(total_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Latency from a line change to ev_valid, counted in rising edges.
    repeat (4) applyStimulus(tog, 1'b1, 1'b0, 1'b0);
    applyStimulus(~tog, 1'b1, 1'b0, 1'b0);
    n = 11;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (ev_valid) begin
        n = k;
        break;
      end
    end
    checkOutput("lit_latency_edges", n, LAT + 1);
    repeat (3) applyStimulus(tog, 1'b1, 1'b1, 1'b0);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      applyStimulus(($urandom_range(0, 2) == 0) ? ~tog : tog,
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0));
    end
    settle();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive end of a toggle-encoded event line. The sender is a t_ff-style flop that inverts its output once per event; this block turns each level change back into a discrete event.
- Queues events in a saturating pending counter and presents them to a consumer over a valid/ready handshake.
- Keeps a wrapping total-event counter and a sticky overflow flag.
- Sits in the same clock domain as the sender. An optional synchronizer supports a foreign-domain sender.

Parameters:
- CNT_W, 4, width of the pending-event counter; max pending = 2^CNT_W-1
- TOT_W, 16, width of the total-event counter; wraps modulo 2^TOT_W

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- tog_in  input  1  toggle-encoded event line; each level change = one event
- enable  input  1  1 = detect events; 0 = ignore changes but keep tracking the level
- ev_ready  input  1  consumer accepts one event this cycle when ev_valid=1
- overflow_clr  input  1  synchronous clear of the overflow flag
- ev_valid  output  1  at least one event pending
- pending  output  CNT_W  number of queued events
- overflow  output  1  sticky; an event arrived while pending was saturated
- total_count  output  TOT_W  all detected events, including dropped ones

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Asserting reset immediately forces:
  - state=S_INIT, ref=0, pending=0, ev_valid=0, overflow=0, total_count=0, synchronizer flops=0.
- Sample s:
  - without the macro, s = tog_in;
  - with the macro, s = output of the 2-flop synchronizer.
- FSM, two states:
  - S_INIT: at the first clk edge after reset deasserts, ref <= s and go to S_RUN. No event is generated, so the startup level of tog_in is never counted.
  - S_RUN: every edge, ref <= s. detect = (s != ref) & enable. Stays in S_RUN until reset.
- When enable=0, changes are absorbed into ref. Re-enabling never produces a spurious event.
- Handshake:
  - ev_valid = (pending != 0), a registered-state output.
  - accept = ev_valid & ev_ready.
  - ev_ready while ev_valid=0 has no effect.
  - ev_valid stays asserted while pending > 0, independent of ev_ready.
- pending update, per edge:
  - detect & !accept: pending+1, saturating at 2^CNT_W-1.
  - !detect & accept: pending-1.
  - detect & accept: pending unchanged, no overflow.
  - Neither: hold.
- Overflow:
  - Set when detect & !accept & pending == 2^CNT_W-1. The event is dropped.
  - overflow_clr clears it. If set and clear occur in the same cycle, set wins.
- total_count: +1 on every detect (including dropped events); wraps from 2^TOT_W-1 to 0.
- Latency, tog_in change to ev_valid:
  - without the macro, change before edge N gives ev_valid=1 after edge N;
  - with the macro, after edge N+2.
- Two changes on consecutive cycles count as two events. A change and change-back between samples is lost by design; the sender must hold each level at least 1 cycle (3 with the synchronizer).
- Reset mid-operation discards pending events and clears the counters. The next edge re-captures ref.

Optional Feature:
- Macro TOGGLE_EVENT_DECODER_SYNC_EN.
- Defined: tog_in passes through a 2-flop synchronizer (reset to 0) before the compare. Latency grows by 2 cycles.
  - S_INIT waits until the synchronizer is primed: it captures ref on the 3rd edge after reset deasserts, with no event.
- Undefined: tog_in is used directly; 1-cycle latency.
- Handshake, counter and overflow rules are identical in both builds.

Test Plan:
- Reset release with tog_in=1 held, enable=1 -> no event; pending=0, total_count=0 after 5 cycles.
- Toggle tog_in 3 times, 2 cycles apart, ev_ready=0 -> pending=3, ev_valid=1, total_count=3. Then ev_ready=1 for 3 cycles -> pending=0, ev_valid=0.
- Toggle every cycle with ev_ready=1 held, CNT_W=4 -> pending stays 1 after the first event, overflow=0.
- ev_ready=0, 17 toggles with CNT_W=4 -> pending=15, overflow=1, total_count=17. Pulse overflow_clr -> overflow=0. Clear coinciding with a 16th-event set -> overflow stays 1.
- enable=0, toggle twice, enable=1, no further toggles -> pending=0. One more toggle -> pending=1.
- Assert reset asynchronously mid-stream with pending=5 -> all outputs 0 before the next clk edge. Repeat with the macro defined and measure toggle-to-ev_valid = 3 edges.
